// File: rtl/banked_ram_if.sv
// Access bus for banked_ram.
//   dread_addr  : byte address of the read access (master -> ram)
//   dread_data  : read data, byte k from dread_addr+k (ram -> master)
//   dread_hit   : registered window-hit flag for last cycle's read (ram -> master)
//   dwrite_addr : byte address of the write access (master -> ram)
//   dwrite_data : write data, byte k to dwrite_addr+k (master -> ram)
//   dwrite_en   : per-byte write enables (master -> ram)
interface banked_ram_if #(
  parameter int unsigned LANES = 2
) ();
  logic [15:0]        dread_addr;
  logic [8*LANES-1:0] dread_data;
  logic               dread_hit;
  logic [15:0]        dwrite_addr;
  logic [8*LANES-1:0] dwrite_data;
  logic [LANES-1:0]   dwrite_en;

  modport master (
    output dread_addr, dwrite_addr, dwrite_data, dwrite_en,
    input  dread_data, dread_hit
  );

  modport slave (
    input  dread_addr, dwrite_addr, dwrite_data, dwrite_en,
    output dread_data, dread_hit
  );
endinterface

// File: rtl/banked_ram.sv
// Windowed byte RAM split into LANES byte banks, with unaligned multi-byte access,
// one-cycle read latency, per-byte read-during-write bypass and a post-reset clear pass.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high reset
//   bus   : banked_ram_if slave modport (read and write ports)
//   busy  : high while the clear sequence runs (and during reset)
module banked_ram #(
  parameter int unsigned ADDRBITS = 10,
  parameter int unsigned LANES    = 2,
  parameter logic [15:0] TOPADDR  = 16'h4000
) (
  input  logic         clk,
  input  logic         reset,
  banked_ram_if.slave  bus,
  output logic         busy
);

  localparam int unsigned Size     = 1 << ADDRBITS;
  localparam int unsigned Rows     = Size / LANES;
  localparam int unsigned LaneBits = $clog2(LANES);
  localparam int unsigned RowBits  = ADDRBITS - LaneBits;
  localparam int unsigned BankW    = (LaneBits == 0) ? 1 : LaneBits;
  localparam logic [15:0] SizeL    = 16'(Size);
  localparam logic [15:0] RamBase  = TOPADDR - SizeL;

  typedef logic [RowBits-1:0]  row_t;
  typedef logic [BankW-1:0]    bank_t;
  typedef logic [ADDRBITS-1:0] off_t;

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e             state_q, state_d;
  row_t               cnt_q, cnt_d;
  logic [8*LANES-1:0] rd_data_q, rd_data_d;
  logic               hit_q, hit_d;

  logic [7:0] mem_q [LANES][Rows];

  // Address decode: offsets relative to the window base; an address below the base
  // wraps to a large offset, so a single unsigned compare covers both window edges.
  logic [15:0] rd_off, wr_off;
  logic        rd_in, wr_in, wr_ok;
  off_t        rd_o [LANES];
  off_t        wr_o [LANES];
  bank_t       rd_bank [LANES];
  bank_t       wr_bank [LANES];
  row_t        rd_row [LANES];
  row_t        wr_row [LANES];

  always_comb begin
    rd_off = bus.dread_addr - RamBase;
    wr_off = bus.dwrite_addr - RamBase;
    rd_in  = rd_off < SizeL;
    wr_in  = wr_off < SizeL;
    for (int k = 0; k < LANES; k++) begin
      // Byte k of an access wraps modulo the window size.
      rd_o[k]    = rd_off[ADDRBITS-1:0] + ADDRBITS'(k);
      wr_o[k]    = wr_off[ADDRBITS-1:0] + ADDRBITS'(k);
      rd_bank[k] = bank_t'(rd_o[k] % LANES);
      wr_bank[k] = bank_t'(wr_o[k] % LANES);
      rd_row[k]  = row_t'(rd_o[k] >> LaneBits);
      wr_row[k]  = row_t'(wr_o[k] >> LaneBits);
    end
  end

  assign wr_ok = (state_q == StReady) && !reset && wr_in;

  // Controller: clear one row per cycle, then serve accesses until reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        if (cnt_q == row_t'(Rows - 1)) begin
          state_d = StReady;
        end else begin
          cnt_d = cnt_q + row_t'(1);
        end
      end
      StReady: state_d = StReady;
      default: state_d = StClear;
    endcase
  end

  // Read path with per-byte bypass of the write being sampled on the same edge.
  always_comb begin
    rd_data_d = '0;
    hit_d     = 1'b0;
    if (state_q == StReady && rd_in) begin
      hit_d = 1'b1;
      for (int k = 0; k < LANES; k++) begin
        rd_data_d[8*k +: 8] = mem_q[rd_bank[k]][rd_row[k]];
        for (int j = 0; j < LANES; j++) begin
          if (wr_ok && bus.dwrite_en[j] && wr_bank[j] == rd_bank[k] &&
              wr_row[j] == rd_row[k]) begin
            rd_data_d[8*k +: 8] = bus.dwrite_data[8*j +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StClear;
      cnt_q     <= '0;
      rd_data_q <= '0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      hit_q     <= hit_d;
    end
  end

  // Storage has no reset; the clear pass establishes its contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == StClear) begin
        for (int b = 0; b < LANES; b++) begin
          mem_q[b][cnt_q] <= 8'h00;
        end
      end else if (wr_ok) begin
        for (int j = 0; j < LANES; j++) begin
          if (bus.dwrite_en[j]) begin
            mem_q[wr_bank[j]][wr_row[j]] <= bus.dwrite_data[8*j +: 8];
          end
        end
      end
    end
  end

  // Outputs are forced quiet for the whole reset assertion, including its first cycle.
  assign busy           = reset || (state_q == StClear);
  assign bus.dread_data = reset ? '0 : rd_data_q;
  assign bus.dread_hit  = reset ? 1'b0 : hit_q;

endmodule

// File: tb/tb_banked_ram.sv
// Self-checking bench for banked_ram (ADDRBITS=10, LANES=2, window 0x3C00-0x3FFF).
module tb_banked_ram;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  banked_ram_if #(.LANES(2)) bus ();

  banked_ram #(
    .ADDRBITS(10),
    .LANES   (2),
    .TOPADDR (16'h4000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ra;
    logic [15:0] wa;
    logic [15:0] wd;
    logic [1:0]  we;
    logic        chk;
    logic [15:0] data;
    logic        hit;
    string       name;
  } vec_t;

  typedef struct {
    int unsigned cyc;
    logic [15:0] data;
    logic        hit;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] ra, input logic [15:0] wa,
                              input logic [15:0] wd, input logic [1:0] we,
                              input logic chk, input logic [15:0] data, input logic hit,
                              input string name);
    vec_t v;
    v.ra = ra; v.wa = wa; v.wd = wd; v.we = we;
    v.chk = chk; v.data = data; v.hit = hit; v.name = name;
    return v;
  endfunction

  // Called at a falling edge: drive the vector, queue its expected read result for the
  // next rising edge, then advance to the following falling edge.
  task automatic step(input vec_t v);
    exp_t e;
    bus.dread_addr  = v.ra;
    bus.dwrite_addr = v.wa;
    bus.dwrite_data = v.wd;
    bus.dwrite_en   = v.we;
    if (v.chk) begin
      e.cyc  = cyc + 1;
      e.data = v.data;
      e.hit  = v.hit;
      e.name = v.name;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(mk(16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0, ""));
  endtask

  // Count busy cycles after reset release, poking a read and a write into the clear.
  task automatic count_busy(output int n);
    vec_t v;
    n = 0;
    while (busy && n < 1000) begin
      v = mk(16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0, "");
      if (n == 3) v = mk(16'h3C00, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0000, 1'b0,
                         "read_during_clear");
      if (n == 5) v = mk(16'h0000, 16'h3C20, 16'h1111, 2'b11, 1'b0, 16'h0000, 1'b0, "");
      step(v);
      n++;
    end
  endtask

  always @(posedge clk) begin : mon
    exp_t e;
    cyc = cyc + 1;
    #1;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check({e.name, ".data"}, 32'(bus.dread_data), 32'(e.data));
      check({e.name, ".hit"}, 32'(bus.dread_hit), 32'(e.hit));
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  vec_t tbl[17];
  int   n;

  initial begin
    tbl[0]  = mk(16'h3C00, 16'h3C01, 16'hBEEF, 2'b11, 1'b1, 16'hEF00, 1'b1, "unal_bypass");
    tbl[1]  = mk(16'h3C02, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h00BE, 1'b1, "unal_3c02");
    tbl[2]  = mk(16'h3C00, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'hEF00, 1'b1, "unal_3c00");
    tbl[3]  = mk(16'h3C00, 16'h3C10, 16'h1234, 2'b11, 1'b1, 16'hEF00, 1'b1, "wr_1234");
    tbl[4]  = mk(16'h3C10, 16'h3C10, 16'hAB00, 2'b10, 1'b1, 16'hAB34, 1'b1, "be_bypass");
    tbl[5]  = mk(16'h3C10, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'hAB34, 1'b1, "be_stored");
    tbl[6]  = mk(16'h3FFE, 16'h3FFF, 16'h5566, 2'b11, 1'b1, 16'h6600, 1'b1, "wrap_bypass");
    tbl[7]  = mk(16'h3FFF, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h5566, 1'b1, "wrap_read");
    tbl[8]  = mk(16'h3C00, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'hEF55, 1'b1, "wrap_bottom");
    tbl[9]  = mk(16'h1000, 16'h1000, 16'hFFFF, 2'b11, 1'b1, 16'h0000, 1'b0, "out_1000");
    tbl[10] = mk(16'h3BFF, 16'h3BFF, 16'hFFFF, 2'b11, 1'b1, 16'h0000, 1'b0, "out_below");
    tbl[11] = mk(16'h4000, 16'h4000, 16'hAAAA, 2'b11, 1'b1, 16'h0000, 1'b0, "out_above");
    tbl[12] = mk(16'h3C00, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'hEF55, 1'b1, "out_no_change");
    tbl[13] = mk(16'h3FFF, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h5566, 1'b1, "top_no_change");
    tbl[14] = mk(16'h3C20, 16'h3C20, 16'h7777, 2'b00, 1'b1, 16'h0000, 1'b1, "en_none");
    tbl[15] = mk(16'h3C20, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0000, 1'b1, "en_none_stored");
    tbl[16] = mk(16'h3C20, 16'h3C21, 16'h0099, 2'b01, 1'b1, 16'h9900, 1'b1, "en_low_bypass");

    reset           = 1'b1;
    bus.dread_addr  = '0;
    bus.dwrite_addr = '0;
    bus.dwrite_data = '0;
    bus.dwrite_en   = '0;
    repeat (3) @(negedge clk);
    check("rst.busy", 32'(busy), 32'd1);
    check("rst.hit", 32'(bus.dread_hit), 32'd0);
    check("rst.data", 32'(bus.dread_data), 32'd0);

    reset = 1'b0;
    count_busy(n);
    check("clear_len", 32'(n), 32'd512);
    check("busy_low", 32'(busy), 32'd0);
    step(mk(16'h3C00, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0000, 1'b1, "cleared_3c00"));
    step(mk(16'h3C20, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0000, 1'b1, "clear_wr_dropped"));

    for (int i = 0; i < 17; i++) step(tbl[i]);

    // Reset from READY, then again at clear row 200.
    reset = 1'b1;
    idle();
    reset = 1'b0;
    repeat (200) idle();
    check("mid_clear.busy", 32'(busy), 32'd1);
    reset = 1'b1;
    idle();
    check("mid_rst.busy", 32'(busy), 32'd1);
    check("mid_rst.hit", 32'(bus.dread_hit), 32'd0);
    idle();
    reset = 1'b0;
    count_busy(n);
    check("reclear_len", 32'(n), 32'd512);
    step(mk(16'h3C01, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0000, 1'b1, "recleared_3c01"));
    step(mk(16'h3FFF, 16'h0000, 16'h0000, 2'b00, 1'b1, 16'h0000, 1'b1, "recleared_3fff"));
    idle();
    idle();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
